// File: rtl/router_pkt_tx_if.sv
// ---------------------------------------------------------------------------
// router_pkt_tx_if
// Bundles the packet request, payload FIFO and router-side signals of the
// packet transmitter so that the bench and the transmitter share one port.
//
//   start        request a new packet (sampled in IDLE only)
//   dest_addr    destination port 0-2 (3 is rejected)
//   payload_len  payload byte count 1-63 (0 is rejected)
//   abort        synchronous cancel of the packet in flight
//   pl_data      first-word-fall-through payload byte
//   pl_rd        payload byte consumed this cycle
//   busy         router stall
//   pkt_valid    header/payload byte valid on data_out
//   data_out     byte to router
//   tx_ready     transmitter idle, start will be accepted
//   done         one-cycle pulse after the parity byte is accepted
//   err          one-cycle pulse for a rejected request
//   pkt_count    packets sent, wraps at 256
//
// slave  : transmitter side
// master : request / payload source / router side
// ---------------------------------------------------------------------------
interface router_pkt_tx_if;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] payload_len;
    logic       abort;
    logic [7:0] pl_data;
    logic       pl_rd;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_ready;
    logic       done;
    logic       err;
    logic [7:0] pkt_count;

    modport slave (
        input  start, dest_addr, payload_len, abort, pl_data, busy,
        output pl_rd, pkt_valid, data_out, tx_ready, done, err, pkt_count
    );

    modport master (
        output start, dest_addr, payload_len, abort, pl_data, busy,
        input  pl_rd, pkt_valid, data_out, tx_ready, done, err, pkt_count
    );
endinterface

// File: rtl/router_pkt_tx.sv
// ---------------------------------------------------------------------------
// router_pkt_tx
// Serialises one packet to the router: a header byte {payload_len,dest_addr},
// payload_len bytes pulled from a FWFT FIFO, then a parity byte that is the
// XOR of header and payload. A one-cycle gap follows every packet.
//
// Ports
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    router_pkt_tx_if.slave (request, payload FIFO, router, status)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; tx_ready=1
// HEADER  | header byte on data_out, pkt_valid=1
// PAYLOAD | payload byte on data_out, pkt_valid=1
// PARITY  | parity byte on data_out, pkt_valid=0
// GAP     | one idle cycle after the packet, done pulses here
// ---------------------------------------------------------------------------
module router_pkt_tx (
    input  logic             clock,
    input  logic             reset,
    router_pkt_tx_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } state_t;

    state_t     state;
    logic [7:0] data_q;
    logic [7:0] parity_q;
    logic [7:0] count_q;
    logic [5:0] remaining;     // payload bytes not yet loaded into data_q
    logic       valid_q;
    logic       done_q;
    logic       err_q;

    logic       req_legal;
    logic       loading;

    assign req_legal = (bus.dest_addr != 2'd3) && (bus.payload_len != 6'd0);

    // A byte is pulled from the FIFO only in the cycle it replaces the one
    // on data_out, i.e. when the router accepts and more payload is owed.
    assign loading   = ((state == ST_HEADER) || (state == ST_PAYLOAD)) &&
                       (remaining != 6'd0);

    assign bus.pl_rd     = !bus.busy && !bus.abort && loading;
    assign bus.tx_ready  = (state == ST_IDLE);
    assign bus.pkt_valid = valid_q;
    assign bus.data_out  = data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.pkt_count = count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            data_q    <= 8'h00;
            parity_q  <= 8'h00;
            count_q   <= 8'h00;
            remaining <= 6'd0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            // Abort overrides a stall: the packet is dropped even if the
            // router is holding the current byte.
            if ((state != ST_IDLE) && bus.abort) begin
                state     <= ST_IDLE;
                data_q    <= 8'h00;
                parity_q  <= 8'h00;
                remaining <= 6'd0;
                valid_q   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            if (req_legal) begin
                                data_q    <= {bus.payload_len, bus.dest_addr};
                                parity_q  <= {bus.payload_len, bus.dest_addr};
                                remaining <= bus.payload_len;
                                valid_q   <= 1'b1;
                                state     <= ST_HEADER;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end

                    ST_HEADER, ST_PAYLOAD: begin
                        if (!bus.busy) begin
                            if (remaining != 6'd0) begin
                                data_q    <= bus.pl_data;
                                parity_q  <= parity_q ^ bus.pl_data;
                                remaining <= remaining - 6'd1;
                                state     <= ST_PAYLOAD;
                            end else begin
                                // parity_q already folds in the last byte
                                data_q  <= parity_q;
                                valid_q <= 1'b0;
                                state   <= ST_PARITY;
                            end
                        end
                    end

                    ST_PARITY: begin
                        if (!bus.busy) begin
                            done_q  <= 1'b1;
                            count_q <= count_q + 8'd1;
                            state   <= ST_GAP;
                        end
                    end

                    ST_GAP: begin
                        state <= ST_IDLE;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// ---------------------------------------------------------------------------
// tb_router_pkt_tx
// Drives router_pkt_tx through directed and randomised packets. The expected
// router stream of every packet is built as a byte list (header, payload,
// XOR parity); an index into that list advances on every non-stalled cycle.
// ---------------------------------------------------------------------------
module tb_router_pkt_tx;

    logic clock = 1'b0;
    logic reset;

    router_pkt_tx_if bus_if ();

    router_pkt_tx dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_count;
    logic [7:0] pay [0:63];

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        bus_if.start       = 1'b0;
        bus_if.dest_addr   = 2'd0;
        bus_if.payload_len = 6'd0;
        bus_if.abort       = 1'b0;
        bus_if.busy        = 1'b0;
        bus_if.pl_data     = 8'h00;
    endtask

    // One packet, cycle by cycle, against the byte-list model.
    // abort_idx / reset_idx select the stream position at which to cancel.
    task automatic xmit_packet(input logic [1:0] addr, input logic [5:0] len,
                               input int busy_pct, input int stall_idx,
                               input int stall_len, input int abort_idx,
                               input int reset_idx, input bit junk_start);
        logic [7:0] exp_bytes[$];
        logic [7:0] par;
        logic       exp_rd;
        int         n;
        int         idx;
        int         ptr;
        int         stall_left;
        int         guard;

        n = int'(len);
        par = {len, addr};
        exp_bytes.push_back(par);
        for (int i = 0; i < n; i++) begin
            exp_bytes.push_back(pay[i]);
            par = par ^ pay[i];
        end
        exp_bytes.push_back(par);

        bus_if.start       = 1'b1;
        bus_if.dest_addr   = addr;
        bus_if.payload_len = len;
        bus_if.abort       = 1'b0;
        bus_if.busy        = 1'($urandom);
        bus_if.pl_data     = 8'($urandom);
        #1;
        n_vec++;
        if (bus_if.tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL req_tx_ready got=%b exp=1", bus_if.tx_ready);
        end
        @(negedge clock);
        bus_if.start = 1'b0;

        idx = 0;
        ptr = 0;
        stall_left = stall_len;
        guard = 0;
        while (idx < n + 2) begin
            if (idx == stall_idx && stall_left > 0) begin
                bus_if.busy = 1'b1;
                stall_left--;
            end else begin
                bus_if.busy = ($urandom_range(99) < busy_pct);
            end
            bus_if.abort = (idx == abort_idx);
            if (junk_start) begin
                bus_if.start       = 1'($urandom);
                bus_if.dest_addr   = 2'($urandom);
                bus_if.payload_len = 6'($urandom);
            end
            bus_if.pl_data = (ptr < n) ? pay[ptr] : 8'($urandom);
            exp_rd = !bus_if.busy && !bus_if.abort && (idx < n);
            #1;
            n_vec++;
            if (bus_if.data_out !== exp_bytes[idx]) begin
                n_err++;
                $display("FAIL data_out idx=%0d got=%h exp=%h", idx, bus_if.data_out, exp_bytes[idx]);
            end
            n_vec++;
            if (bus_if.pkt_valid !== 1'(idx <= n)) begin
                n_err++;
                $display("FAIL pkt_valid idx=%0d got=%b exp=%b", idx, bus_if.pkt_valid, idx <= n);
            end
            n_vec++;
            if (bus_if.pl_rd !== exp_rd) begin
                n_err++;
                $display("FAIL pl_rd idx=%0d got=%b exp=%b", idx, bus_if.pl_rd, exp_rd);
            end
            n_vec++;
            if (bus_if.tx_ready !== 1'b0 || bus_if.done !== 1'b0 || bus_if.err !== 1'b0) begin
                n_err++;
                $display("FAIL busy_flags idx=%0d got rdy/done/err=%b%b%b exp=000",
                         idx, bus_if.tx_ready, bus_if.done, bus_if.err);
            end
            n_vec++;
            if (bus_if.pkt_count !== exp_count) begin
                n_err++;
                $display("FAIL pkt_count_mid got=%0d exp=%0d", bus_if.pkt_count, exp_count);
            end

            if (idx == reset_idx) begin
                reset = 1'b1;
                #1;
                n_vec++;
                if (bus_if.tx_ready !== 1'b1 || bus_if.pkt_valid !== 1'b0 ||
                    bus_if.data_out !== 8'h00 || bus_if.done !== 1'b0 ||
                    bus_if.err !== 1'b0 || bus_if.pkt_count !== 8'h00 ||
                    bus_if.pl_rd !== 1'b0) begin
                    n_err++;
                    $display("FAIL async_reset got rdy=%b pv=%b do=%h done=%b err=%b cnt=%0d rd=%b exp=1 0 00 0 0 0 0",
                             bus_if.tx_ready, bus_if.pkt_valid, bus_if.data_out, bus_if.done,
                             bus_if.err, bus_if.pkt_count, bus_if.pl_rd);
                end
                exp_count = 8'h00;
                idle_inputs();
                #1;
                reset = 1'b0;
                @(negedge clock);
                #1;
                n_vec++;
                if (bus_if.done !== 1'b0 || bus_if.tx_ready !== 1'b1 || bus_if.pkt_count !== 8'h00) begin
                    n_err++;
                    $display("FAIL post_reset got done=%b rdy=%b cnt=%0d exp=0 1 0",
                             bus_if.done, bus_if.tx_ready, bus_if.pkt_count);
                end
                return;
            end

            if (bus_if.abort) begin
                @(negedge clock);
                idle_inputs();
                #1;
                n_vec++;
                if (bus_if.tx_ready !== 1'b1 || bus_if.pkt_valid !== 1'b0 ||
                    bus_if.data_out !== 8'h00 || bus_if.done !== 1'b0 ||
                    bus_if.pkt_count !== exp_count) begin
                    n_err++;
                    $display("FAIL abort got rdy=%b pv=%b do=%h done=%b cnt=%0d exp=1 0 00 0 %0d",
                             bus_if.tx_ready, bus_if.pkt_valid, bus_if.data_out,
                             bus_if.done, bus_if.pkt_count, exp_count);
                end
                return;
            end

            if (exp_rd) ptr++;
            if (!bus_if.busy) idx++;
            guard++;
            if (guard > 2000) begin
                n_err++;
                $display("FAIL stream_timeout got idx=%0d exp=%0d", idx, n + 2);
                idle_inputs();
                return;
            end
            @(negedge clock);
        end

        // gap cycle
        bus_if.busy = 1'($urandom);
        if (junk_start) bus_if.start = 1'($urandom);
        exp_count = exp_count + 8'd1;
        #1;
        n_vec++;
        if (bus_if.done !== 1'b1 || bus_if.pkt_valid !== 1'b0 ||
            bus_if.tx_ready !== 1'b0 || bus_if.pl_rd !== 1'b0) begin
            n_err++;
            $display("FAIL gap got done=%b pv=%b rdy=%b rd=%b exp=1 0 0 0",
                     bus_if.done, bus_if.pkt_valid, bus_if.tx_ready, bus_if.pl_rd);
        end
        n_vec++;
        if (bus_if.pkt_count !== exp_count) begin
            n_err++;
            $display("FAIL pkt_count got=%0d exp=%0d", bus_if.pkt_count, exp_count);
        end
        @(negedge clock);
        idle_inputs();
        #1;
        n_vec++;
        if (bus_if.tx_ready !== 1'b1 || bus_if.done !== 1'b0) begin
            n_err++;
            $display("FAIL after_gap got rdy=%b done=%b exp=1 0", bus_if.tx_ready, bus_if.done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clock);
        #1;
        n_vec++;
        if (bus_if.tx_ready !== 1'b1 || bus_if.pl_rd !== 1'b0 || bus_if.pkt_valid !== 1'b0 ||
            bus_if.data_out !== 8'h00 || bus_if.done !== 1'b0 || bus_if.err !== 1'b0 ||
            bus_if.pkt_count !== 8'h00) begin
            n_err++;
            $display("FAIL reset_values got rdy=%b rd=%b pv=%b do=%h done=%b err=%b cnt=%0d exp=1 0 0 00 0 0 0",
                     bus_if.tx_ready, bus_if.pl_rd, bus_if.pkt_valid, bus_if.data_out,
                     bus_if.done, bus_if.err, bus_if.pkt_count);
        end
        reset = 1'b0;
        exp_count = 8'h00;
        @(negedge clock);
        #1;
        n_vec++;
        if (bus_if.tx_ready !== 1'b1 || bus_if.pl_rd !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset got rdy=%b rd=%b exp=1 0", bus_if.tx_ready, bus_if.pl_rd);
        end
    endtask

    task automatic test_single();
        pay[0] = 8'hA5;
        xmit_packet(2'd1, 6'd1, 0, -1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_stall();
        pay[0] = 8'h11;
        pay[1] = 8'h22;
        pay[2] = 8'h33;
        xmit_packet(2'd2, 6'd3, 0, 2, 3, -1, -1, 1'b0);
    endtask

    task automatic test_reject();
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                bus_if.dest_addr   = 2'd3;
                bus_if.payload_len = 6'($urandom_range(0, 63));
            end else begin
                bus_if.dest_addr   = 2'($urandom_range(0, 3));
                bus_if.payload_len = 6'd0;
            end
            bus_if.start = 1'b1;
            @(negedge clock);
            bus_if.start = 1'b0;
            #1;
            n_vec++;
            if (bus_if.err !== 1'b1 || bus_if.pkt_valid !== 1'b0 || bus_if.tx_ready !== 1'b1) begin
                n_err++;
                $display("FAIL reject got err=%b pv=%b rdy=%b exp=1 0 1",
                         bus_if.err, bus_if.pkt_valid, bus_if.tx_ready);
            end
            @(negedge clock);
            #1;
            n_vec++;
            if (bus_if.err !== 1'b0 || bus_if.tx_ready !== 1'b1) begin
                n_err++;
                $display("FAIL reject_pulse got err=%b rdy=%b exp=0 1", bus_if.err, bus_if.tx_ready);
            end
        end
        idle_inputs();
    endtask

    task automatic test_abort_idle();
        bus_if.start       = 1'b1;
        bus_if.dest_addr   = 2'd1;
        bus_if.payload_len = 6'd5;
        bus_if.abort       = 1'b1;
        @(negedge clock);
        idle_inputs();
        #1;
        n_vec++;
        if (bus_if.tx_ready !== 1'b1 || bus_if.pkt_valid !== 1'b0 || bus_if.err !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle got rdy=%b pv=%b err=%b exp=1 0 0",
                     bus_if.tx_ready, bus_if.pkt_valid, bus_if.err);
        end
    endtask

    task automatic test_abort_payload();
        for (int k = 0; k < 3; k++) begin
            int len;
            len = $urandom_range(2, 20);
            for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
            xmit_packet(2'($urandom_range(0, 2)), 6'(len), 25, -1, 0,
                        $urandom_range(1, len), -1, 1'b1);
        end
    endtask

    task automatic test_max_len();
        for (int i = 0; i < 63; i++) pay[i] = 8'(i);
        xmit_packet(2'd0, 6'd63, 0, -1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            int len;
            len = $urandom_range(1, 63);
            for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
            xmit_packet(2'($urandom_range(0, 2)), 6'(len), 30, -1, 0, -1, -1, 1'b1);
        end
    endtask

    task automatic test_reset_parity();
        int len;
        len = $urandom_range(1, 8);
        for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
        xmit_packet(2'd1, 6'(len), 20, -1, 0, -1, len + 1, 1'b0);
    endtask

    task automatic test_back_to_back_wrap();
        for (int k = 0; k < 256; k++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
            xmit_packet(2'($urandom_range(0, 2)), 6'(len), 20, -1, 0, -1, -1, 1'b1);
        end
        n_vec++;
        if (bus_if.pkt_count !== 8'h00) begin
            n_err++;
            $display("FAIL wrap got=%0d exp=0", bus_if.pkt_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_stall();
        test_reject();
        test_abort_idle();
        test_abort_payload();
        test_max_len();
        test_random();
        test_reset_parity();
        test_back_to_back_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have ports: clock in 1, rising-edge clock; reset in 1, asynchronous active-high reset.
REQ-002 SHALL have ports: start in 1 (packet request); dest_addr in 2 (destination port 0-2); payload_len in 6 (payload bytes, 1-63); abort in 1 (synchronous cancel).
REQ-003 SHALL have ports: pl_data in 8 (first-word-fall-through payload byte); pl_rd out 1 (payload byte consumed this cycle).
REQ-004 SHALL have ports: busy in 1 (router stall); pkt_valid out 1; data_out out 8 (byte to router).
REQ-005 SHALL have ports: tx_ready out 1 (idle, start accepted); done out 1 (packet-complete pulse); err out 1 (rejected-request pulse); pkt_count out 8 (packets sent).

Function
REQ-006 SHALL implement states IDLE, HEADER, PAYLOAD, PARITY, GAP; tx_ready = (state==IDLE), combinational.
REQ-007 SHALL treat a byte as accepted at a rising edge where busy=0 and state is HEADER, PAYLOAD or PARITY; while busy=1, data_out, pkt_valid, the counter and parity SHALL hold.
REQ-008 IDLE, start=1, dest_addr!=3, payload_len!=0: SHALL register header {payload_len,dest_addr} into data_out, set pkt_valid=1, parity register=header, remaining=payload_len, and go to HEADER (1-cycle latency).
REQ-009 IDLE, start=1 with dest_addr==3 or payload_len==0: SHALL pulse err for one cycle and stay in IDLE with outputs unchanged.
REQ-010 start SHALL be ignored outside IDLE.
REQ-011 pl_rd SHALL be combinational = busy=0 & state in {HEADER, PAYLOAD} & remaining>0, where remaining counts payload bytes not yet loaded.
REQ-012 On header acceptance: data_out<=pl_data, parity<=parity^pl_data, remaining decrements, go to PAYLOAD.
REQ-013 On payload acceptance with remaining>0: load the next pl_data in the same way; with remaining==0: data_out<=parity, pkt_valid<=0, go to PARITY.
REQ-014 pkt_valid SHALL be 1 for exactly the header and every payload byte, and 0 while the parity byte is driven.
REQ-015 Parity byte SHALL equal the XOR of the header and all payload bytes.
REQ-016 On parity acceptance: pulse done for one cycle, increment pkt_count (mod 256, 255->0 wraps), go to GAP.
REQ-017 GAP SHALL last exactly one cycle with pkt_valid=0; the next state SHALL be IDLE.
REQ-018 abort=1 in any non-IDLE state: next edge SHALL force IDLE, pkt_valid=0, data_out=0, no done, no pkt_count change; pl_rd SHALL be 0 while abort=1.
REQ-019 abort in IDLE SHALL have no effect, and IDLE start SHALL NOT be accepted while abort=1.
REQ-020 busy=1 during the parity byte SHALL hold parity on data_out until accepted.
REQ-021 Minimum packet spacing: header, len payload bytes, parity and GAP = len+3 cycles when busy=0.

Reset
REQ-022 reset=1 SHALL asynchronously force state IDLE, pkt_valid=0, data_out=8'h00, parity=0, remaining=0, done=0, err=0, pkt_count=0.
REQ-023 During and immediately after reset, tx_ready SHALL be 1 and pl_rd SHALL be 0.
REQ-024 reset asserted mid-packet SHALL discard the packet with no done pulse.

Verification
REQ-025 Single byte: start, addr=1, len=1, pl_data=A5, busy=0 -> data_out 05(pv=1), A5(pv=1), A0(pv=0), done pulse, pkt_count=1, tx_ready after GAP.
REQ-026 Stall: addr=2, len=3, payload 11,22,33, busy=1 for 3 cycles on the 2nd payload byte -> 22 is held 4 cycles, pl_rd=0 during the stall, parity=0E^11^22^33=0E.
REQ-027 Reject: addr=3 or len=0 -> err pulses 1 cycle, pkt_valid stays 0, tx_ready stays 1.
REQ-028 Max length: len=63, addr=0, incrementing payload 00..3E -> 63 pl_rd pulses, header FC, parity = FC^XOR(00..3E), total 66 cycles to GAP.
REQ-029 Abort/reset: abort during PAYLOAD -> IDLE next cycle with pkt_count unchanged; reset during PARITY -> all outputs at reset values immediately, with no done pulse.
REQ-030 Wrap: 256 back-to-back packets -> pkt_count returns to 0, and start is ignored while the FSM is not in IDLE.
